// File: rtl/dram_stream_pkg.sv
// Shared types and constants for the distributed-RAM stream reader.
package dram_stream_pkg;

  localparam int unsigned DEPTH  = 128;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned REM_W  = 8;

  typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

  // A LEN of zero stands for the full RAM depth.
  function automatic logic [REM_W-1:0] decode_len(input logic [ADDR_W-1:0] len);
    return (len == '0) ? REM_W'(DEPTH) : {1'b0, len};
  endfunction

endpackage

// File: rtl/dram_bit_packer.sv
// Serial-to-parallel bit packer: inserts one bit per enabled cycle at a running index.
module dram_bit_packer #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word_c,
  output logic              full_c
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] word_r;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  pos;

  // word_c already contains the bit being inserted this cycle.
  always_comb begin
    pos    = (MSB_FIRST != 0) ? IDX_W'(WORD_W - 1) - idx : idx;
    word_c = word_r;
    if (shift_en) word_c[pos] = bit_in;
    full_c = (idx == IDX_W'(WORD_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= '0;
      idx    <= '0;
    end else if (clear) begin
      word_r <= '0;
      idx    <= '0;
    end else if (shift_en) begin
      word_r <= word_c;
      idx    <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/dram_stream_reader.sv
// Reads a 128x1 async-read RAM bit by bit and streams packed words over valid/ready.
// Optional even-parity output M_PAR when DRAM_STREAM_READER_PARITY_EN is defined.
module dram_stream_reader
  import dram_stream_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [6:0]        BASE,
  input  logic [6:0]        LEN,
  output logic              BUSY,
  output logic [6:0]        MEM_A,
  input  logic              MEM_Q,
  output logic [WORD_W-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST
`ifdef DRAM_STREAM_READER_PARITY_EN
  , output logic            M_PAR
`endif
);

  state_t            state, state_d;
  logic [REM_W-1:0]  rem, rem_d;
  logic [ADDR_W-1:0] addr_d;
  logic [WORD_W-1:0] data_d;
  logic              valid_d, last_d, busy_d;
  logic              pk_clear, pk_shift;
  logic [WORD_W-1:0] pk_word_c;
  logic              pk_full_c;
`ifdef DRAM_STREAM_READER_PARITY_EN
  logic              par_d;
`endif

  dram_bit_packer #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_packer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clear    (pk_clear),
    .shift_en (pk_shift),
    .bit_in   (MEM_Q),
    .word_c   (pk_word_c),
    .full_c   (pk_full_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    rem_d    = rem;
    addr_d   = MEM_A;
    data_d   = M_DATA;
    valid_d  = M_VALID;
    last_d   = M_LAST;
    busy_d   = BUSY;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
`ifdef DRAM_STREAM_READER_PARITY_EN
    par_d    = M_PAR;
`endif
    case (state)
      IDLE: begin
        if (START) begin
          addr_d   = BASE;
          rem_d    = decode_len(LEN);
          pk_clear = 1'b1;
          busy_d   = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        pk_shift = 1'b1;
        addr_d   = MEM_A + ADDR_W'(1);
        rem_d    = rem - REM_W'(1);
        if (pk_full_c || rem == REM_W'(1)) begin
          data_d  = pk_word_c;
          valid_d = 1'b1;
          last_d  = (rem == REM_W'(1));
`ifdef DRAM_STREAM_READER_PARITY_EN
          par_d   = ^pk_word_c;
`endif
          state_d = OUT;
        end
      end
      OUT: begin
        if (M_READY) begin
          valid_d = 1'b0;
          if (M_LAST) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            pk_clear = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      rem     <= '0;
      MEM_A   <= '0;
      M_DATA  <= '0;
      M_VALID <= 1'b0;
      M_LAST  <= 1'b0;
      BUSY    <= 1'b0;
`ifdef DRAM_STREAM_READER_PARITY_EN
      M_PAR   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      rem     <= rem_d;
      MEM_A   <= addr_d;
      M_DATA  <= data_d;
      M_VALID <= valid_d;
      M_LAST  <= last_d;
      BUSY    <= busy_d;
`ifdef DRAM_STREAM_READER_PARITY_EN
      M_PAR   <= par_d;
`endif
    end
  end

endmodule

// File: doc/dram_stream_reader.md
Name: dram_stream_reader

Overview:
- Read-side engine for a 128x1 asynchronous-read distributed RAM (sync write, combinational read).
- Drives the RAM address and samples its data output one bit per cycle.
- Packs the bits into WORD_W-bit words and emits them on a valid/ready stream.
- Used to dump configuration or lookup bitmaps that a separate writer loaded through the RAM's write port.

Parameters:
- WORD_W, 8, output word width in bits; legal 1..16.
- MSB_FIRST, 0: 0 = first fetched bit lands in word bit 0; 1 = first fetched bit lands in bit WORD_W-1.

Ports:
- CLK  in  1  sole clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle command pulse; accepted only when BUSY=0.
- BASE  in  7  start bit address; sampled with START.
- LEN  in  7  bit count; 0 encodes 128; sampled with START.
- BUSY  out  1  high from the cycle after START is accepted until the final word handshakes.
- MEM_A  out  7  address to RAM; registered.
- MEM_Q  in  1  RAM combinational data out.
- M_DATA  out  WORD_W  packed word.
- M_VALID  out  1  word valid.
- M_READY  in  1  consumer ready.
- M_LAST  out  1  marks the final word of a command.

Behaviour:
- Reset (async, RST_N=0):
  - State=IDLE.
  - BUSY=0, MEM_A=0, M_DATA=0, M_VALID=0, M_LAST=0.
  - Bit counter and remaining counter cleared.
- IDLE:
  - START=1 latches MEM_A<=BASE and REM<=(LEN==0 ? 128 : LEN) (8-bit counter).
  - Clears the packing register and bit index; BUSY<=1; goes to FETCH.
  - START while BUSY=1 is ignored, with no side effects.
- FETCH:
  - Each cycle, sample MEM_Q (address already stable on MEM_A) into the packing register at the current bit index.
  - Then MEM_A<=MEM_A+1, wrapping modulo 128 (127 -> 0), and REM<=REM-1.
  - When the bit index reaches WORD_W-1 or REM==1, move the packing register to M_DATA, set M_VALID<=1 and M_LAST<=(REM==1), and go to OUT.
- Partial final word: unfetched bit positions are driven 0.
- OUT:
  - Hold M_DATA, M_VALID and M_LAST stable until M_VALID&M_READY.
  - On that handshake, M_VALID<=0.
  - If M_LAST: BUSY<=0, go to IDLE.
  - Otherwise: clear the bit index and go to FETCH.
  - MEM_A is not advanced while in OUT.
- Latency:
  - With M_READY held 1, the first M_VALID rises WORD_W+1 cycles after the START edge.
  - Steady throughput is one word per WORD_W+1 cycles.
- Bounds:
  - LEN=1 gives a single word with M_LAST=1 and only one bit fetched.
  - LEN=0 reads 128 bits with full wrap-around of the address.
- Reset mid-operation aborts immediately: no M_LAST is issued and nothing is retained.
- M_READY is ignored whenever M_VALID=0.

Optional Feature:
- Macro DRAM_STREAM_READER_PARITY_EN.
- Defined:
  - Adds output port M_PAR (1 bit), reset 0.
  - M_PAR is the even parity (XOR) of the fetched bits of the current word, excluding pad bits.
  - It is registered together with M_DATA and obeys the same hold rules.
- Undefined: port and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package dram_stream_pkg holds:
  - state enum {IDLE, FETCH, OUT};
  - constant DEPTH=128;
  - constant ADDR_W=7;
  - the LEN-decode function (0 -> 128).
- One sub-module, dram_bit_packer, is natural:
  - inputs: clear, shift-enable, bit, MSB_FIRST;
  - outputs: packed word and the "word full" flag.
- The FSM and counters stay in the top.

Test Plan:
- For all scenarios, the RAM model's INIT=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; WORD_W=8, MSB_FIRST=0, M_READY=1.
- START, BASE=0, LEN=16 -> two words, 8'h10 then 8'h32; M_LAST only on the second; first M_VALID 9 cycles after START; BUSY drops after the second handshake.
- START, BASE=124, LEN=8 -> MEM_A visits 124..127, 0..3; one word = 8'h00 (bits 127:124 = 4'h0, bits 3:0 = 4'h0); M_LAST=1.
- LEN=0, BASE=0 -> 16 words, reproducing INIT LSB-first; M_LAST on word 16; MEM_A ends at 0.
- LEN=3, BASE=4 -> one word 8'h01 (bits 6:4 = 3'b001; upper bits padded 0); with the macro defined, M_PAR=1.
- M_READY held 0 for 5 cycles during OUT, plus a START pulse while BUSY -> M_DATA/M_VALID stable, MEM_A frozen, START ignored; RST_N pulsed mid-FETCH -> all outputs 0 the same cycle, next START behaves normally.
